// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32 M-extension divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Divide-by-zero quotient; sliced down to the instance width (widths up to 64).
    localparam int unsigned DIV0_Q_W = 64;
    localparam logic [DIV0_Q_W-1:0] DIV0_Q = '1;

    // Step counter must be able to hold DATA_W.
    function automatic int unsigned cnt_width(input int unsigned data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/add_sub.sv
// Ripple adder/subtractor: S = X + (Y ^ {Cin}) + Cin, so Cin=1 subtracts.
module add_sub #(
    parameter int unsigned data_size = 32
) (
    input  logic [data_size-1:0] X,
    input  logic [data_size-1:0] Y,
    input  logic                 Cin,
    output logic [data_size-1:0] S,
    output logic                 Cout
);

    logic [data_size:0] sum;

    assign sum  = {1'b0, X} + {1'b0, Y ^ {data_size{Cin}}} + {{data_size{1'b0}}, Cin};
    assign S    = sum[data_size-1:0];
    assign Cout = sum[data_size];

endmodule

// File: rtl/seq_divider.sv
// Restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle on magnitudes,
// signs restored in a final cycle.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] Q,
    output logic [DATA_W-1:0] R
);

    localparam int unsigned        CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DATA_W - 1);

    div_state_e        state;
    div_state_e        state_nxt;

    logic [DATA_W-1:0] dvd;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] dsr;
    logic [DATA_W-1:0] a_orig;
    logic              sign_q;
    logic              sign_r;
    logic              div0;
    logic [CNT_W-1:0]  cnt;

    logic              accept;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic [DATA_W:0]   trial_x;
    logic [DATA_W:0]   trial_y;
    logic [DATA_W:0]   trial_s;
    logic              trial_co;
    logic              trial_ok;
    logic [DATA_W-1:0] q_fix;
    logic [DATA_W-1:0] r_fix;

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign a_mag  = (signed_op && A[DATA_W-1]) ? -A : A;
    assign b_mag  = (signed_op && B[DATA_W-1]) ? -B : B;

    // Trial subtraction of the shifted partial remainder against |B|.
    assign trial_x = {rem, dvd[DATA_W-1]};
    assign trial_y = {1'b0, dsr};

    add_sub #(
        .data_size(DATA_W + 1)
    ) u_trial (
        .X   (trial_x),
        .Y   (trial_y),
        .Cin (1'b1),
        .S   (trial_s),
        .Cout(trial_co)
    );

    // No borrow means the difference is non-negative (its top bit is then always clear).
    assign trial_ok = trial_co & ~trial_s[DATA_W];

    assign q_fix = div0 ? DATA_W'(DIV0_Q) : (sign_q ? -dvd : dvd);
    assign r_fix = div0 ? a_orig          : (sign_r ? -rem : rem);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? CALC : IDLE;
            CALC:    state_nxt = (cnt == CNT_LAST) ? SIGN : CALC;
            SIGN:    state_nxt = DONE;
            DONE:    state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            CALC:    busy = 1'b1;
            SIGN:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: the dividend register shifts out dividend bits and shifts in quotient bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd    <= '0;
            rem    <= '0;
            dsr    <= '0;
            a_orig <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            div0   <= 1'b0;
            cnt    <= '0;
            Q      <= '0;
            R      <= '0;
        end else if (accept) begin
            dvd    <= a_mag;
            dsr    <= b_mag;
            a_orig <= A;
            sign_q <= signed_op & (A[DATA_W-1] ^ B[DATA_W-1]);
            sign_r <= signed_op & A[DATA_W-1];
            div0   <= (B == '0);
            rem    <= '0;
            cnt    <= '0;
        end else if (state == CALC) begin
            rem <= trial_ok ? trial_s[DATA_W-1:0] : trial_x[DATA_W-1:0];
            dvd <= {dvd[DATA_W-2:0], trial_ok};
            cnt <= cnt + CNT_W'(1);
        end else if (state == SIGN) begin
            Q <= q_fix;
            R <= r_fix;
        end
    end

endmodule
